// File: rtl/key_repeat.sv
// key_repeat: turns a raw USB keycode into one-frame movement pulses, with
// delayed auto-shift for left/right/down and one-shot rotate/hard drop.
module key_repeat #(
    parameter int DAS_DELAY  = 10,
    parameter int DAS_PERIOD = 3
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    output logic        move_left,
    output logic        move_right,
    output logic        soft_drop,
    output logic        rotate,
    output logic        hard_drop,
    output logic        key_held
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

    state_t     state, state_nxt;
    logic [2:0] code, code_nxt, dec;
    logic [7:0] cnt, cnt_nxt;
    logic [4:0] pulse, pulse_nxt;

    // key ids: 0 none, 1 left, 2 right, 3 down, 4 rotate, 5 hard drop
    always_comb
        dec = keycode == 16'h0004 ? 3'd1 :
              keycode == 16'h0007 ? 3'd2 :
              keycode == 16'h0016 ? 3'd3 :
              keycode == 16'h001A ? 3'd4 :
              keycode == 16'h002C ? 3'd5 : 3'd0;

    // code is forced to none in IDLE, so "dec != code" also covers a fresh press from IDLE
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        cnt_nxt   = cnt;
        pulse_nxt = '0;
        if (dec != code) begin
            code_nxt  = dec;
            cnt_nxt   = '0;
            state_nxt = dec == 3'd0 ? IDLE : dec <= 3'd3 ? DELAY : LOCK;
            pulse_nxt = dec == 3'd0 ? 5'd0 : 5'b10000 >> (dec - 3'd1);
        end else if (state == DELAY) begin
            if (cnt == 8'(DAS_DELAY - 1)) begin
                pulse_nxt = 5'b10000 >> (code - 3'd1);
                cnt_nxt   = '0;
                state_nxt = REPEAT;
            end else
                cnt_nxt = cnt + 8'd1;
        end else if (state == REPEAT) begin
            if (cnt == 8'(DAS_PERIOD - 1)) begin
                pulse_nxt = 5'b10000 >> (code - 3'd1);
                cnt_nxt   = '0;
            end else
                cnt_nxt = cnt + 8'd1;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset)
        if (!Reset) begin
            state <= IDLE;
            code  <= '0;
            cnt   <= '0;
            pulse <= '0;
        end else begin
            state <= state_nxt;
            code  <= code_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
        end

    assign {move_left, move_right, soft_drop, rotate, hard_drop} = pulse;
    assign key_held = state != IDLE;
endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat: directed and random keycode streams against a frame-age model
// of the auto-shift rules.
module tb_key_repeat;
    localparam int D = 10;
    localparam int P = 3;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] keycode = 16'h0004;
    logic        move_left, move_right, soft_drop, rotate, hard_drop, key_held;

    int errors = 0;
    int checks = 0;
    int prev_id = 0;
    int age = 0;
    logic [5:0] exp_out = '0;

    key_repeat #(.DAS_DELAY(D), .DAS_PERIOD(P)) dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .move_left(move_left), .move_right(move_right), .soft_drop(soft_drop),
        .rotate(rotate), .hard_drop(hard_drop), .key_held(key_held)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic int key_id(input logic [15:0] k);
        case (k)
            16'h0004: return 1;
            16'h0007: return 2;
            16'h0016: return 3;
            16'h001A: return 4;
            16'h002C: return 5;
            default:  return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (L R S Rot H held)", tag, got, exp);
        end
    endtask

    // Age = edges since the current key was first seen; pulses fall at age 0
    // and, for repeatable keys, at D, D+P, D+2P, ...
    task automatic model_edge();
        int id;
        logic [4:0] pl;
        id = key_id(keycode);
        pl = '0;
        if (!Reset || id == 0) begin
            prev_id = 0;
            exp_out = '0;
        end else begin
            age = (id != prev_id) ? 0 : age + 1;
            prev_id = id;
            if (age == 0 || (id <= 3 && age >= D && (age - D) % P == 0))
                pl[5 - id] = 1'b1;
            exp_out = {pl, 1'b1};
        end
    endtask

    task automatic step(input logic [15:0] k, input logic r, input string tag);
        @(negedge frame_clk);
        keycode = k;
        Reset = r;
        @(posedge frame_clk);
        #1;
        model_edge();
        check(tag, {move_left, move_right, soft_drop, rotate, hard_drop, key_held}, exp_out);
    endtask

    initial begin
        #1;
        check("reset_init", {move_left, move_right, soft_drop, rotate, hard_drop, key_held}, 6'b0);
        step(16'h0004, 1'b0, "reset_hold");
        step(16'h0004, 1'b1, "first_edge_left");
        step(16'h0000, 1'b1, "release");
        repeat (20) step(16'h0007, 1'b1, "hold_right");
        step(16'h0000, 1'b1, "release_right");
        repeat (30) step(16'h001A, 1'b1, "hold_rotate");
        step(16'h0000, 1'b1, "release_rotate");
        repeat (13) step(16'h0004, 1'b1, "left_to_repeat");
        repeat (12) step(16'h0016, 1'b1, "switch_down");
        step(16'h0000, 1'b1, "release_down");
        repeat (11) step(16'h0016, 1'b1, "down_before_reset");
        #2 Reset = 1'b0;
        #1;
        prev_id = 0;
        check("async_reset", {move_left, move_right, soft_drop, rotate, hard_drop, key_held}, 6'b0);
        step(16'h0016, 1'b0, "down_in_reset");
        step(16'h0016, 1'b1, "down_after_reset");
        repeat (12) step(16'h0016, 1'b1, "down_after_reset_hold");
        step(16'h0007, 1'b1, "switch_right");
        step(16'h0000, 1'b1, "none_gap");
        step(16'h0007, 1'b1, "repress_right");
        step(16'h002C, 1'b1, "hard_drop");
        step(16'h002C, 1'b1, "hard_drop_hold");
        step(16'h0000, 1'b1, "release_hard");
        step(16'h0005, 1'b1, "unknown_0005");
        step(16'h1A04, 1'b1, "unknown_1a04");
        step(16'h0000, 1'b1, "idle");
        for (int n = 0; n < 300; n++) begin
            logic [15:0] pool [8];
            logic [15:0] k;
            int len;
            pool = '{16'h0000, 16'h0004, 16'h0007, 16'h0016, 16'h001A, 16'h002C, 16'h0005, 16'h1A04};
            k = pool[$urandom_range(0, 7)];
            len = $urandom_range(1, 25);
            for (int c = 0; c < len; c++)
                step(k, $urandom_range(0, 49) != 0, "random");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_repeat.md
# key_repeat

Converts the raw 16-bit USB keycode into single-frame movement command pulses for the piece-motion logic, with Tetris-style delayed auto-shift (DAS) for left/right/down and one-shot behaviour for rotate and hard drop. Sits between the keyboard/keycode source and the motion block, clocked on the frame clock. Exactly one command pulse is produced per qualifying event, so a held key never floods the mover.

## Interface
- DAS_DELAY, 10: frames from the initial press pulse to the first auto-repeat pulse; legal range 1..255.
- DAS_PERIOD, 3: frames between successive auto-repeat pulses; legal range 1..255.
- frame_clk  in  1  sole clock, one edge per video frame.
- Reset  in  1  one clock; reset is asynchronous and active-low.
- keycode  in  16  current key from the keyboard interface; 0x0000 = no key.
- move_left  out  1  one-cycle pulse: shift piece left.
- move_right  out  1  one-cycle pulse: shift piece right.
- soft_drop  out  1  one-cycle pulse: move piece down one row.
- rotate  out  1  one-cycle pulse: rotate piece.
- hard_drop  out  1  one-cycle pulse: drop piece to floor.
- key_held  out  1  high while a recognised key is latched (any state except IDLE).

## Operation
- Decode on full 16 bits, exact match only: 0x0004 left (a), 0x0007 right (d), 0x0016 down (s), 0x001A rotate (w), 0x002C hard drop (space); every other value, including 0x0000, is "none".
- Left/right/down are repeatable; rotate/hard drop are one-shot.
- Registers: state (IDLE, DELAY, REPEAT, LOCK), latched code (3-bit key id), 8-bit counter cnt, five registered pulse outputs.
- At most one pulse output is high in any cycle; all pulses default low every edge unless set below.
- IDLE: keycode recognised -> pulse that key, latch it, cnt <= 0, go DELAY (repeatable) or LOCK (one-shot). Otherwise stay.
- Change rule (DELAY, REPEAT, LOCK), evaluated first: keycode decodes differently from latched key -> if new key recognised, treat as a fresh press exactly as from IDLE (pulse, latch, cnt <= 0, new state); if none, go IDLE with no pulse.
- DELAY, key unchanged: cnt == DAS_DELAY-1 -> pulse latched key, cnt <= 0, go REPEAT; else cnt <= cnt+1.
- REPEAT, key unchanged: cnt == DAS_PERIOD-1 -> pulse latched key, cnt <= 0; else cnt <= cnt+1.
- LOCK, key unchanged: no pulse, stay until release or change.
- cnt is 8-bit unsigned and never exceeds max(DAS_DELAY, DAS_PERIOD)-1; no wrap occurs.

## Timing
- Reset low (any time, async): state IDLE, cnt 0, latched key none, all pulse outputs 0, key_held 0; held until first frame_clk edge after Reset deasserts. Reset mid-repeat aborts with no pulse; a key still held after release counts as a fresh press on the first edge.
- Latency: recognised key sampled at edge N -> its pulse is high from edge N to edge N+1 (registered, one cycle wide).
- Key held continuously from edge 0: pulses after edges 0, DAS_DELAY, DAS_DELAY+DAS_PERIOD, DAS_DELAY+2*DAS_PERIOD, ...
- Key released at edge R: no pulse at R or later; key_held low after R.
- Release-and-repress with one none frame between: counts as new press, immediate pulse.
- Direct switch key A -> key B at the same edge: B pulses at that edge, DAS timing restarts from that edge; A never pulses again.
- key_held is registered and reflects state after each edge.

## Test plan
- Reset low with keycode 0x0004 -> all outputs 0; release Reset, first edge -> move_left pulses, key_held 1.
- Hold 0x0007 for 20 frames, defaults -> move_right high after edges 0, 10, 13, 16, 19 only; no other output ever high.
- Hold 0x001A for 30 frames -> rotate high exactly once at edge 0; key_held 1 throughout; release -> key_held 0 next edge.
- Hold 0x0004 to edge 12 (in REPEAT), switch to 0x0016 at edge 13 -> soft_drop at 13, next at 23; no move_left after 10.
- Hold 0x0016, pull Reset low at frame 11 for 2 frames, release with key still held -> outputs 0 during reset, soft_drop on first edge after, then again 10 edges later.
- keycode 0x0005, then 0x1A04 -> no pulse, key_held stays 0.
